// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers diff = sum - b (mod 2^WIDTH), one LSB-first bit per shift.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] rreg;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             start;
    logic             step;
    logic             last;
    logic             bit_d;
    logic             borrow_nx;

    // One full-subtractor bit slice on the current LSBs
    always_comb begin
        bit_d     = sreg[0] ^ breg[0] ^ borrow;
        borrow_nx = (~sreg[0] & breg[0]) | (~(sreg[0] ^ breg[0]) & borrow);
    end

    // Next-state and control decode
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    start    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (shift) begin
                    step = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        last     = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    start    = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg       <= '0;
            breg       <= '0;
            rreg       <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            if (start) begin
                sreg   <= sum;
                breg   <= b;
                rreg   <= '0;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (step) begin
                rreg   <= {bit_d, rreg[WIDTH-1:1]};
                sreg   <= sreg >> 1;
                breg   <= breg >> 1;
                borrow <= borrow_nx;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    diff       <= {bit_d, rreg[WIDTH-1:1]};
                    borrow_out <= borrow_nx;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow = borrow into MSB xor borrow out of MSB, captured on the final shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= borrow ^ borrow_nx;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
